// File: rtl/load_store_unit.sv
// Single-beat load/store unit: sizes, aligns and sign-extends pipeline memory ops onto a req/gnt/rvalid bus.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module load_store_unit #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        memWR,
  input  logic [2:0]  memCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FLT} state_t;

  typedef struct packed {
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] sz_of(input logic [2:0] c);
    case (c)
      3'b000, 3'b011, 3'b101: sz_of = 2'd0;
      3'b001, 3'b100, 3'b110: sz_of = 2'd1;
      default:                sz_of = 2'd2;
    endcase
  endfunction

  function automatic logic is_st(input logic [2:0] c);
    is_st = (c >= 3'd5);
  endfunction

  state_t state, nstate;
  req_t   req_q;
  logic   in_ok, cap;
  logic [1:0]  sz, off;
  logic [3:0]  be_raw;
  logic [31:0] lane_sh, ld_ext;
  logic        sext;
  logic [NUM_LANES-1:0][VEC_W-1:0] st_data;

  always_comb begin
    in_ok = (is_st(memCtrl) == memWR);
    if (TRAP && sz_of(memCtrl) == 2'd1 && addr[0])         in_ok = 1'b0;
    if (TRAP && sz_of(memCtrl) == 2'd2 && addr[1:0] != '0) in_ok = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     req_q <= '0;
    else if (state == IDLE && start) req_q <= {memWR, memCtrl, addr, wdata};
  end

  // Low address bits below the access width are dropped, so a misaligned
  // half/word is force-aligned (only reachable when trapping is off).
  always_comb begin
    sz = sz_of(req_q.ctrl);
    case (sz)
      2'd0:    begin off = req_q.addr[1:0];       be_raw = 4'b0001 << off; end
      2'd1:    begin off = {req_q.addr[1], 1'b0}; be_raw = 4'b0011 << off; end
      default: begin off = 2'b00;                 be_raw = 4'b1111;        end
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign st_data[l] = (sz == 2'd0) ? req_q.wdata[VEC_W-1:0] :
                        (sz == 2'd1) ? req_q.wdata[VEC_W*(l%2) +: VEC_W] :
                                       req_q.wdata[VEC_W*l +: VEC_W];
  end

  always_comb begin
    sext    = (req_q.ctrl == 3'b000) || (req_q.ctrl == 3'b001);
    lane_sh = bus_rdata >> {off, 3'b000};
    case (sz)
      2'd0:    ld_ext = {{24{sext & lane_sh[7]}},  lane_sh[7:0]};
      2'd1:    ld_ext = {{16{sext & lane_sh[15]}}, lane_sh[15:0]};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    cap    = 1'b0;
    case (state)
      IDLE: if (start) nstate = in_ok ? REQ : FLT;
      REQ:
        if (bus_gnt) begin
          if (req_q.wr)        nstate = DONE;
          else if (bus_rvalid) begin nstate = DONE; cap = 1'b1; end
          else                 nstate = WAIT;
        end
      WAIT: if (bus_rvalid) begin nstate = DONE; cap = 1'b1; end
      DONE: nstate = IDLE;
      FLT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rdata <= '0;
    else if (cap) rdata <= ld_ext;
  end

  assign busy      = (state == REQ) || (state == WAIT);
  assign done      = (state == DONE);
  assign fault     = (state == FLT);
  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req & req_q.wr;
  assign bus_addr  = bus_req ? {req_q.addr[31:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be_raw : '0;
  assign bus_wdata = bus_we ? st_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit against a latency/byte-lane reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, memWR;
  logic [2:0]  memCtrl;
  logic [31:0] addr, wdata;
  logic        busy, done, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;

  int          nchk = 0, nfail = 0;
  logic [31:0] rd_model = '0;
  int          dat;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .memWR(memWR), .memCtrl(memCtrl),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; gd = cycles of bus_req before gnt, rd = cycles after gnt before rvalid.
  task automatic txn(input logic wr, input logic [2:0] ctrl, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rdv,
                     input int gd, input int rd, output int done_at);
    int nb, off, dk, last;
    bit st, ok, sx, exp_req;
    logic [31:0] exp_addr, exp_wd, ext;
    logic [3:0]  exp_be;
    logic [7:0]  rb[4];
    logic [15:0] h;
    st = (ctrl >= 3'd5);
    sx = (ctrl <= 3'd1);
    nb = (ctrl == 3'd0 || ctrl == 3'd3 || ctrl == 3'd5) ? 1 :
         (ctrl == 3'd1 || ctrl == 3'd4 || ctrl == 3'd6) ? 2 : 4;
    ok = (st == wr);
    if (TRAP && (a % nb) != 0) ok = 1'b0;
    off      = ((a % 4) / nb) * nb;
    exp_addr = a & ~32'd3;
    exp_be   = 4'(((1 << nb) - 1) << off);
    for (int j = 0; j < 4; j++) begin
      exp_wd[8*j +: 8] = wd[8*(j % nb) +: 8];
      rb[j] = rdv[8*j +: 8];
    end
    h = {rb[(off + 1) % 4], rb[off]};
    if (nb == 1)      ext = sx ? 32'($signed(rb[off])) : 32'(rb[off]);
    else if (nb == 2) ext = sx ? 32'($signed(h)) : 32'(h);
    else              ext = rdv;
    dk   = !ok ? 0 : (st ? 2 + gd : 2 + gd + rd);
    last = ok ? dk : 1;

    @(negedge clk);
    start = 1'b1; memWR = wr; memCtrl = ctrl; addr = a; wdata = wd;
    @(posedge clk);
    done_at = 0;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (ok && !st && k == dk) rd_model = ext;
      if (done && done_at == 0) done_at = k;
      exp_req = ok && (k <= 1 + gd);
      chk("busy",  32'(busy),  32'(ok && k < dk));
      chk("done",  32'(done),  32'(ok && k == dk));
      chk("fault", 32'(fault), 32'(!ok && k == 1));
      chk("bus_req", 32'(bus_req), 32'(exp_req));
      chk("bus_we",  32'(bus_we),  32'(exp_req && st));
      chk("bus_addr", bus_addr, exp_req ? exp_addr : 32'd0);
      chk("bus_be", 32'(bus_be), exp_req ? 32'(exp_be) : 32'd0);
      chk("bus_wdata", bus_wdata, (exp_req && st) ? exp_wd : 32'd0);
      chk("rdata", rdata, rd_model);
      bus_gnt    = ok && (k == 1 + gd);
      bus_rvalid = ok && !st && (k == 1 + gd + rd);
      bus_rdata  = bus_rvalid ? rdv : $urandom;
      // Junk starts while the unit is occupied must be ignored.
      start   = (k <= last) ? 1'($urandom % 2) : 1'b0;
      memWR   = 1'($urandom % 2);
      memCtrl = 3'($urandom % 8);
      addr    = $urandom;
      wdata   = $urandom;
      @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; memWR = 1'b0; memCtrl = '0; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;

    txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1, 1, dat);
    chk("lb_done_at", 32'(dat), 32'd4);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);

    txn(1'b1, 3'b110, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 3, 0, dat);
    chk("sh_done_at", 32'(dat), 32'd5);
    chk("sh_rdata_kept", rdata, 32'hFFFF_FF80);

    txn(1'b0, 3'b100, 32'h0000_0000, 32'h0, 32'h1234_8001, 1, 0, dat);
    chk("lhu_done_at", 32'(dat), 32'd3);
    chk("lhu_rdata", rdata, 32'h0000_8001);

    txn(1'b1, 3'b010, 32'h0000_0040, 32'h1111_2222, 32'h0, 0, 0, dat);
    chk("mismatch_no_done", 32'(dat), 32'd0);

    txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0, 2, dat);
    chk("lw_mis_done_at", 32'(dat), TRAP ? 32'd0 : 32'd4);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] c;
      logic       w;
      c = 3'($urandom % 8);
      w = ($urandom % 8 == 0) ? (c < 3'd5) : (c >= 3'd5);
      txn(w, c, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), dat);
    end

    // Reset while waiting for load data, then a stray rvalid after release.
    @(negedge clk);
    start = 1'b1; memWR = 1'b0; memCtrl = 3'b010; addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; bus_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_bus_be", 32'(bus_be), 32'd0);
    chk("mid_rst_bus_addr", bus_addr, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    rd_model = '0;
    @(negedge clk);
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    bus_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_done", 32'(done), 32'd0);
      chk("late_fault", 32'(fault), 32'd0);
      chk("late_busy", 32'(busy), 32'd0);
      chk("late_rdata", rdata, 32'd0);
      @(negedge clk);
    end

    txn(1'b0, 3'b001, 32'h0000_0012, 32'h0, 32'hF00F_1234, 2, 1, dat);
    chk("post_rst_lh", rdata, 32'hFFFF_F00F);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
